// File: rtl/fsm_event_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : fsm_event_conditioner
// Description : Event-input front end for the control FSM. Each raw line
//               is passed through a 2-flop synchronizer and a per-channel
//               one-hot debounce FSM that produces a clean registered level,
//               single-cycle rise/fall pulses and a sticky glitch flag.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               raw_in     - asynchronous raw event lines, one per channel
//               enable     - 1 = conditioning active, 0 = channels held idle
//               clr_glitch - per-channel clear for the glitch flag
//               evt_level  - debounced level, registered
//               evt_rise   - one-cycle pulse on evt_level 0->1
//               evt_fall   - one-cycle pulse on evt_level 1->0
//               glitch     - sticky: a pending transition was aborted
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_event_conditioner #(
  parameter int NCH        = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] raw_in,
  input  logic           enable,
  input  logic [NCH-1:0] clr_glitch,
  output logic [NCH-1:0] evt_level,
  output logic [NCH-1:0] evt_rise,
  output logic [NCH-1:0] evt_fall,
  output logic [NCH-1:0] glitch
);

  // The counter only ever holds 0..DEB_CYCLES-1, so clog2 bits suffice.
  localparam int                 CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_LOW  = 4'b0001,
    S_RISE = 4'b0010,
    S_HIGH = 4'b0100,
    S_FALL = 4'b1000
  } state_e;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; free-running regardless of enable so that a
  // re-enable sees the current line state immediately.
  // --------------------------------------------------------------------------
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce FSM
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic             s;
    logic             set_glitch;

    assign s = sync2_q[i];

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      set_glitch = 1'b0;

      if (!enable) begin
        // Disabling drops the level silently: no fall pulse.
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end else begin
        case (state_q)
          S_LOW: begin
            if (s) begin
              state_d = S_RISE;
              cnt_d   = CNT_ONE;
            end
          end
          S_RISE: begin
            if (s) begin
              if (cnt_q == CNT_LAST) begin
                state_d = S_HIGH;
                cnt_d   = '0;
                level_d = 1'b1;
                rise_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              state_d    = S_LOW;
              cnt_d      = '0;
              set_glitch = 1'b1;
            end
          end
          S_HIGH: begin
            if (!s) begin
              state_d = S_FALL;
              cnt_d   = CNT_ONE;
            end
          end
          S_FALL: begin
            if (!s) begin
              if (cnt_q == CNT_LAST) begin
                state_d = S_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
                fall_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              state_d    = S_HIGH;
              cnt_d      = '0;
              set_glitch = 1'b1;
            end
          end
          default: begin
            // Corrupted one-hot encoding: recover quietly to idle.
            state_d = S_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
          end
        endcase
      end

      // A new abort takes priority over a clear on the same edge.
      glitch_d = set_glitch | (glitch_q & ~clr_glitch[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= S_LOW;
        cnt_q    <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        glitch_q <= glitch_d;
      end
    end

    assign evt_level[i] = level_q;
    assign evt_rise[i]  = rise_q;
    assign evt_fall[i]  = fall_q;
    assign glitch[i]    = glitch_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_event_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_event_conditioner
// Description : Self-checking bench for fsm_event_conditioner. A run-length
//               model of the debounce rules is compared against the DUT on
//               every falling clock edge; directed scenarios add literal
//               expectations at hand-computed edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_event_conditioner;

  localparam int NCH = 3;
  localparam int DEB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] raw_in;
  logic           enable;
  logic [NCH-1:0] clr_glitch;
  logic [NCH-1:0] evt_level;
  logic [NCH-1:0] evt_rise;
  logic [NCH-1:0] evt_fall;
  logic [NCH-1:0] glitch;

  always #5 clk = ~clk;

  fsm_event_conditioner #(
    .NCH        (NCH),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .enable     (enable),
    .clr_glitch (clr_glitch),
    .evt_level  (evt_level),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall),
    .glitch     (glitch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: the line seen by the debouncer is raw_in delayed by two edges.
  // A level change is accepted once DEB consecutive enabled samples differ
  // from the current level; a run broken early is an aborted transition.
  // --------------------------------------------------------------------------
  logic [NCH-1:0] m_p1, m_p2;
  logic [NCH-1:0] m_level, m_rise, m_fall, m_glitch;
  int             m_run [NCH];

  initial begin
    logic sv;
    logic setg;
    m_p1 = '0; m_p2 = '0;
    m_level = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_p1 = '0; m_p2 = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          sv = m_p2[i];
          m_rise[i] = 1'b0;
          m_fall[i] = 1'b0;
          if (!enable) begin
            m_level[i] = 1'b0;
            m_run[i]   = 0;
            if (clr_glitch[i]) m_glitch[i] = 1'b0;
          end else begin
            setg = 1'b0;
            if (sv != m_level[i]) begin
              m_run[i] = m_run[i] + 1;
              if (m_run[i] == DEB) begin
                m_level[i] = sv;
                m_rise[i]  = sv;
                m_fall[i]  = ~sv;
                m_run[i]   = 0;
              end
            end else begin
              if (m_run[i] > 0) setg = 1'b1;
              m_run[i] = 0;
            end
            if (setg) m_glitch[i] = 1'b1;
            else if (clr_glitch[i]) m_glitch[i] = 1'b0;
          end
        end
        m_p2 = m_p1;
        m_p1 = raw_in;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_level",  evt_level, m_level);
    check("model_rise",   evt_rise,  m_rise);
    check("model_fall",   evt_fall,  m_fall);
    check("model_glitch", glitch,    m_glitch);
    check("rise_fall_exclusive", evt_rise & evt_fall, '0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    finish_run();
  end

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b1;
    raw_in     = '0;
    enable     = 1'b1;
    clr_glitch = '0;
    #1;
    rst_n  = 1'b0;
    raw_in = 3'b111;
    tick(3);
    check("reset_level",  evt_level, 3'b000);
    check("reset_rise",   evt_rise,  3'b000);
    check("reset_fall",   evt_fall,  3'b000);
    check("reset_glitch", glitch,    3'b000);
    rst_n  = 1'b1;
    raw_in = 3'b000;
    tick(8);
    check("post_reset_level", evt_level, 3'b000);
    check("post_reset_rise",  evt_rise,  3'b000);

    // Clean rise on channel 0: captured at edge k, visible after k+5.
    raw_in = 3'b001;
    tick(5);
    check("rise_early_level", evt_level, 3'b000);
    tick(1);
    check("rise_level", evt_level, 3'b001);
    check("rise_pulse", evt_rise,  3'b001);
    tick(1);
    check("rise_pulse_end", evt_rise, 3'b000);
    tick(8);
    raw_in = 3'b000;
    tick(5);
    check("fall_early_level", evt_level, 3'b001);
    check("fall_early_pulse", evt_fall,  3'b000);
    tick(1);
    check("fall_pulse", evt_fall,  3'b001);
    check("fall_level", evt_level, 3'b000);
    tick(1);
    check("fall_pulse_end", evt_fall, 3'b000);

    // Channel 1 high for three captured samples: aborted rise.
    raw_in = 3'b010;
    tick(3);
    raw_in = 3'b000;
    tick(2);
    check("glitch_before_abort", glitch, 3'b000);
    tick(1);
    check("glitch_set",      glitch,    3'b010);
    check("glitch_no_level", evt_level, 3'b000);
    clr_glitch = 3'b010;
    tick(1);
    clr_glitch = 3'b000;
    check("glitch_cleared", glitch, 3'b000);

    // Same abort with clear on the abort edge: set wins.
    raw_in = 3'b010;
    tick(3);
    raw_in = 3'b000;
    tick(2);
    clr_glitch = 3'b010;
    tick(1);
    clr_glitch = 3'b000;
    check("glitch_set_wins", glitch, 3'b010);
    clr_glitch = 3'b010;
    tick(1);
    clr_glitch = 3'b000;
    check("glitch_recleared", glitch, 3'b000);
    tick(4);

    // All channels rise together.
    raw_in = 3'b111;
    tick(5);
    check("simul_rise_early", evt_rise, 3'b000);
    tick(1);
    check("simul_rise",  evt_rise,  3'b111);
    check("simul_level", evt_level, 3'b111);
    tick(6);

    // Two-sample low dip on channel 2 while high.
    raw_in = 3'b011;
    tick(2);
    raw_in = 3'b111;
    tick(2);
    check("dip_glitch_early", glitch, 3'b000);
    tick(1);
    check("dip_glitch", glitch,    3'b100);
    check("dip_level",  evt_level, 3'b111);
    tick(6);
    check("dip_level_held", evt_level, 3'b111);
    clr_glitch = 3'b100;
    tick(1);
    clr_glitch = 3'b000;

    // Enable drop: level clears silently; re-enable with lines high.
    enable = 1'b0;
    tick(1);
    check("disable_level", evt_level, 3'b000);
    check("disable_fall",  evt_fall,  3'b000);
    tick(3);
    enable = 1'b1;
    tick(3);
    check("reenable_early", evt_rise, 3'b000);
    tick(1);
    check("reenable_rise",  evt_rise,  3'b111);
    check("reenable_level", evt_level, 3'b111);

    // Reset in the middle of a pending rise.
    raw_in = 3'b000;
    tick(8);
    raw_in = 3'b001;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrise_reset_level", evt_level, 3'b000);
    check("midrise_reset_rise",  evt_rise,  3'b000);
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("after_reset_early", evt_rise, 3'b000);
    tick(1);
    check("after_reset_rise",  evt_rise,  3'b001);
    check("after_reset_level", evt_level, 3'b001);

    // Reset while the level is high.
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("high_reset_level", evt_level, 3'b000);
    check("high_reset_fall",  evt_fall,  3'b000);
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("after_reset2_early", evt_level, 3'b000);
    tick(1);
    check("after_reset2_rise", evt_rise, 3'b001);

    raw_in = 3'b000;
    tick(10);
    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/fsm_event_conditioner.md
Name: fsm_event_conditioner

Overview:
- Front-end conditioning stage for the control FSM's event inputs (in1/in2/in3).
- Synchronizes asynchronous raw event lines, debounces each one, and outputs clean, registered levels plus single-cycle rising and falling pulses.
- The control FSM consumes `evt_level` or `evt_rise` directly as its `in*` inputs.
- Each channel runs its own 4-state one-hot debounce FSM.

Parameters:
- NCH, 3, number of independent event channels.
- DEB_CYCLES, 4, consecutive synchronized samples required to accept a level change. Legal range is ≥2; the counter width is derived internally as $clog2(DEB_CYCLES).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- raw_in  in  NCH  asynchronous raw event lines
- enable  in  1  1 = conditioning active; 0 = all channels forced idle
- clr_glitch  in  NCH  per-channel clear for the glitch flag
- evt_level  out  NCH  debounced level, registered
- evt_rise  out  NCH  one-cycle pulse when `evt_level` goes 0→1
- evt_fall  out  NCH  one-cycle pulse when `evt_level` goes 1→0
- glitch  out  NCH  sticky flag: a pending transition was aborted

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops, counters, `evt_level`, `evt_rise`, `evt_fall` and `glitch` all go to 0.
  - Every channel FSM goes to S_LOW.
  - Releasing reset produces no pulses.
- Synchronizer:
  - 2-flop chain per channel, always running, independent of `enable`.
  - Call the second-flop output `s`.
- Channel FSM (one-hot: S_LOW, S_RISE, S_HIGH, S_FALL), evaluated every edge while `enable`=1:
  - S_LOW: if s=1 → S_RISE, cnt=1. Otherwise stay.
  - S_RISE:
    - s=1 and cnt==DEB_CYCLES-1 → S_HIGH; `evt_level`=1; `evt_rise`=1 for one cycle.
    - s=1 otherwise → cnt++.
    - s=0 → S_LOW, cnt=0, `glitch` set.
  - S_HIGH: if s=0 → S_FALL, cnt=1. Otherwise stay.
  - S_FALL:
    - s=0 and cnt==DEB_CYCLES-1 → S_LOW; `evt_level`=0; `evt_fall`=1 for one cycle.
    - s=0 otherwise → cnt++.
    - s=1 → S_HIGH, cnt=0, `glitch` set.
  - Illegal or non-one-hot state → S_LOW, cnt=0, `evt_level`=0, no pulse.
- Latency:
  - A raw change captured at edge k gives the `evt_level` change and pulse visible after edge k+DEB_CYCLES+1.
  - With the default DEB_CYCLES=4 this is 5 edges.
- Pulses:
  - `evt_rise` and `evt_fall` are registered, last exactly one cycle, and are never asserted together on one channel.
  - Minimum spacing between a rise and the following fall on one channel is DEB_CYCLES cycles.
- Enable:
  - When `enable`=0, at the next edge every FSM goes to S_LOW, cnt=0, `evt_level`=0.
  - `evt_rise` and `evt_fall` are forced 0; no fall pulse is generated by disabling.
  - `glitch` holds its value.
  - On re-enable with s already 1: the first enabled edge e enters S_RISE, and the level and rise pulse appear after edge e+DEB_CYCLES-1.
- Glitch flag:
  - Sticky until `clr_glitch[i]`=1.
  - If set and clear occur on the same edge, set wins.
- Channels are fully independent. Simultaneous events on several channels produce coincident pulses.
- Reset mid-operation: outputs clear immediately and asynchronously; no pulse is emitted on entry to or exit from reset.

Test Plan:
- Reset value check: hold rst_n=0 with raw_in=3'b111 → all outputs 0. Release, then hold raw_in=0 → outputs remain 0 and no pulse appears.
- Clean rise/fall, DEB_CYCLES=4, raw_in[0]=1 captured at edge 10:
  - `evt_level[0]`=1 and `evt_rise[0]`=1 after edge 15; `evt_rise[0]`=0 after edge 16.
  - raw_in[0]=0 captured at edge 30 → `evt_fall[0]` pulses after edge 35 and `evt_level[0]`=0.
- Glitch rejection:
  - raw_in[1] high for exactly 3 captured cycles → no `evt_level[1]`/`evt_rise[1]`; `glitch[1]`=1 after abort.
  - Pulse `clr_glitch[1]` → `glitch[1]`=0.
  - Repeat with a glitch aborting on the same edge that clr_glitch is high → `glitch[1]` stays 1.
- Simultaneous channels: raw_in 000→111 on one edge → all three `evt_rise` bits pulse on the same cycle. A 2-cycle low dip on channel 2 while high → `glitch[2]`=1 and no `evt_fall[2]`.
- Enable drop: with `evt_level[0]`=1, drop `enable` → `evt_level[0]`=0 next edge and no `evt_fall`. Re-enable at edge e with raw still high → `evt_rise[0]` after edge e+3.
- Reset mid-operation: assert rst_n mid-S_RISE and again while `evt_level`=1 → outputs 0 immediately. After release with raw high, the full DEB_CYCLES+1 latency applies before `evt_rise`.
